// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared datapath types and limits for the register files
package cpu_types_pkg;

    localparam int RF_MAX_PORTS = 4;
    localparam int RF_ADDR_W    = 5;
    localparam int WORD_W       = 32;

    typedef logic [RF_ADDR_W-1:0] rf_sel_t;
    typedef logic [WORD_W-1:0]    word_t;

endpackage

// File: rtl/register_file_mp_if.sv
// rtl/register_file_mp_if.sv - read/write/issue bus of the multi-port register file
interface register_file_mp_if
    import cpu_types_pkg::*;
#(
    parameter int DATA_W = $bits(word_t),
    parameter int NREGS  = 2 ** $bits(rf_sel_t),
    parameter int ADDR_W = $clog2(NREGS),
    parameter int NREAD  = 2,
    parameter int NWRITE = 2
) ();

    logic [NREAD*ADDR_W-1:0]  rsel;
    logic [NREAD*DATA_W-1:0]  rdat;
    logic [NREAD-1:0]         rbusy;
    logic [NWRITE-1:0]        wen;
    logic [NWRITE*ADDR_W-1:0] wsel;
    logic [NWRITE*DATA_W-1:0] wdat;
    logic                     issue_en;
    logic [ADDR_W-1:0]        issue_sel;
    logic [NREGS-1:0]         busy_vec;
    logic                     wconflict;

    modport master (
        output rsel, wen, wsel, wdat, issue_en, issue_sel,
        input  rdat, rbusy, busy_vec, wconflict
    );

    modport slave (
        input  rsel, wen, wsel, wdat, issue_en, issue_sel,
        output rdat, rbusy, busy_vec, wconflict
    );

endinterface

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register busy scoreboard for issue-stage hazard detection
module rf_scoreboard #(
    parameter int NREGS    = 32,
    parameter int NWRITE   = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter int ADDR_W   = $clog2(NREGS)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NWRITE-1:0]        wen,
    input  logic [NWRITE*ADDR_W-1:0] wsel,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_sel,
    output logic [NREGS-1:0]         wr_mask,
    output logic [NREGS-1:0]         iss_mask,
    output logic [NREGS-1:0]         busy_vec
);

    logic [NREGS-1:0] busy_next;

    always_comb begin
        wr_mask  = '0;
        iss_mask = '0;
        for (int j = 0; j < NWRITE; j++) begin
            if (wen[j]) wr_mask[wsel[j*ADDR_W +: ADDR_W]] = 1'b1;
        end
        if (issue_en && !(ZERO_REG && issue_sel == '0)) iss_mask[issue_sel] = 1'b1;
        // a same-cycle issue is a newer producer than the retiring write, so set beats clear
        busy_next = (busy_vec & ~wr_mask) | iss_mask;
        if (ZERO_REG) busy_next[0] = 1'b0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) busy_vec <= '0;
        else     busy_vec <= busy_next;
    end

endmodule

// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - multi-port register file with bypass, write priority and scoreboard
module register_file_mp
    import cpu_types_pkg::*;
#(
    parameter int DATA_W   = $bits(word_t),
    parameter int NREGS    = 2 ** $bits(rf_sel_t),
    parameter int ADDR_W   = $clog2(NREGS),
    parameter int NREAD    = 2,
    parameter int NWRITE   = 2,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1
) (
    input logic               CLK,
    input logic               RST,
    register_file_mp_if.slave bus
);

    logic [DATA_W-1:0] regs [NREGS];
    logic [ADDR_W-1:0] wsel_a [NWRITE];
    logic [DATA_W-1:0] wdat_a [NWRITE];
    logic [NWRITE-1:0] wr_ok;
    logic              collide;
    logic [NREGS-1:0]  wr_mask;
    logic [NREGS-1:0]  iss_mask;
    logic [NREAD*DATA_W-1:0] rdat_w;
    logic [NREAD-1:0]        rbusy_w;

    always_comb begin
        collide = 1'b0;
        for (int j = 0; j < NWRITE; j++) begin
            wsel_a[j] = bus.wsel[j*ADDR_W +: ADDR_W];
            wdat_a[j] = bus.wdat[j*DATA_W +: DATA_W];
            wr_ok[j]  = bus.wen[j] && !(ZERO_REG && wsel_a[j] == '0);
        end
        // collisions on reg 0 still count even though the write itself is dropped
        for (int j = 0; j < NWRITE; j++) begin
            for (int k = j + 1; k < NWRITE; k++) begin
                if (bus.wen[j] && bus.wen[k] && wsel_a[j] == wsel_a[k]) collide = 1'b1;
            end
        end
    end

    // ascending port order: the last nonblocking write to an address, the highest port, wins
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int r = 0; r < NREGS; r++) regs[r] <= '0;
            bus.wconflict <= 1'b0;
        end else begin
            for (int j = 0; j < NWRITE; j++) begin
                if (wr_ok[j]) regs[wsel_a[j]] <= wdat_a[j];
            end
            bus.wconflict <= collide;
        end
    end

    rf_scoreboard #(
        .NREGS    (NREGS),
        .NWRITE   (NWRITE),
        .ZERO_REG (ZERO_REG),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .CLK       (CLK),
        .RST       (RST),
        .wen       (bus.wen),
        .wsel      (bus.wsel),
        .issue_en  (bus.issue_en),
        .issue_sel (bus.issue_sel),
        .wr_mask   (wr_mask),
        .iss_mask  (iss_mask),
        .busy_vec  (bus.busy_vec)
    );

    always_comb begin : read_mux
        logic [ADDR_W-1:0] s;
        logic [DATA_W-1:0] d;
        logic              b;
        s       = '0;
        d       = '0;
        b       = 1'b0;
        rdat_w  = '0;
        rbusy_w = '0;
        for (int i = 0; i < NREAD; i++) begin
            s = bus.rsel[i*ADDR_W +: ADDR_W];
            d = regs[s];
            b = bus.busy_vec[s];
            if (BYPASS) begin
                for (int j = 0; j < NWRITE; j++) begin
                    if (bus.wen[j] && wsel_a[j] == s) d = wdat_a[j];
                end
                if (wr_mask[s] && !iss_mask[s]) b = 1'b0;
            end
            if (ZERO_REG && s == '0) d = '0;
            // bypass paths must not leak write data while reset holds storage cleared
            if (RST) begin
                d = '0;
                b = 1'b0;
            end
            rdat_w[i*DATA_W +: DATA_W] = d;
            rbusy_w[i]                 = b;
        end
    end

    assign bus.rdat  = rdat_w;
    assign bus.rbusy = rbusy_w;

endmodule

// File: tb/tb_register_file_mp.sv
// tb/tb_register_file_mp.sv - randomized and directed bench for register_file_mp
module tb_register_file_mp;
    import cpu_types_pkg::*;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    register_file_mp_if #(.DATA_W(32), .NREGS(32), .NREAD(2), .NWRITE(2)) bb ();
    register_file_mp_if #(.DATA_W(32), .NREGS(32), .NREAD(2), .NWRITE(2)) nb ();
    register_file_mp_if #(.DATA_W(64), .NREGS(64), .NREAD(4), .NWRITE(1)) wb ();

    register_file_mp #(.DATA_W(32), .NREGS(32), .NREAD(2), .NWRITE(2), .BYPASS(1), .ZERO_REG(1))
        u_byp (.CLK(CLK), .RST(RST), .bus(bb));
    register_file_mp #(.DATA_W(32), .NREGS(32), .NREAD(2), .NWRITE(2), .BYPASS(0), .ZERO_REG(1))
        u_nob (.CLK(CLK), .RST(RST), .bus(nb));
    register_file_mp #(.DATA_W(64), .NREGS(64), .NREAD(4), .NWRITE(1), .BYPASS(1), .ZERO_REG(1))
        u_wide (.CLK(CLK), .RST(RST), .bus(wb));

    // reference state for the two 32x32 instances (identical stimulus, differ only in bypass)
    logic [31:0] m_reg [32];
    logic [31:0] m_busy;
    logic        m_conf;

    logic [1:0]  c_wen;
    logic [4:0]  c_wsel [2];
    logic [31:0] c_wdat [2];
    logic [4:0]  c_rsel [2];
    logic        c_ien;
    logic [4:0]  c_isel;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) m_reg[r] = '0;
        m_busy = '0;
        m_conf = 1'b0;
    endtask

    task automatic drive();
        bb.wen = c_wen;                   nb.wen = c_wen;
        bb.wsel = {c_wsel[1], c_wsel[0]}; nb.wsel = {c_wsel[1], c_wsel[0]};
        bb.wdat = {c_wdat[1], c_wdat[0]}; nb.wdat = {c_wdat[1], c_wdat[0]};
        bb.rsel = {c_rsel[1], c_rsel[0]}; nb.rsel = {c_rsel[1], c_rsel[0]};
        bb.issue_en = c_ien;              nb.issue_en = c_ien;
        bb.issue_sel = c_isel;            nb.issue_sel = c_isel;
    endtask

    task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
        c_wen = '0;
        c_wsel[0] = '0; c_wsel[1] = '0;
        c_wdat[0] = '0; c_wdat[1] = '0;
        c_rsel[0] = r0; c_rsel[1] = r1;
        c_ien = 1'b0;
        c_isel = '0;
        drive();
    endtask

    function automatic logic written(input logic [4:0] sel);
        return (c_wen[0] && c_wsel[0] == sel) || (c_wen[1] && c_wsel[1] == sel);
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] sel, input bit byp);
        logic [31:0] v;
        if (RST || sel == 0) return '0;
        v = m_reg[sel];
        if (byp) begin
            if (c_wen[0] && c_wsel[0] == sel) v = c_wdat[0];
            if (c_wen[1] && c_wsel[1] == sel) v = c_wdat[1];
        end
        return v;
    endfunction

    function automatic logic exp_busy(input logic [4:0] sel, input bit byp);
        if (RST) return 1'b0;
        if (byp && written(sel) && !(c_ien && c_isel == sel && sel != 0)) return 1'b0;
        return m_busy[sel];
    endfunction

    task automatic check_comb();
        for (int i = 0; i < 2; i++) begin
            check("byp_rdat",  bb.rdat[i*32 +: 32], exp_read(c_rsel[i], 1'b1));
            check("nob_rdat",  nb.rdat[i*32 +: 32], exp_read(c_rsel[i], 1'b0));
            check("byp_rbusy", bb.rbusy[i], exp_busy(c_rsel[i], 1'b1));
            check("nob_rbusy", nb.rbusy[i], exp_busy(c_rsel[i], 1'b0));
        end
        check("byp_busy_vec", bb.busy_vec, RST ? 32'h0 : m_busy);
        check("nob_busy_vec", nb.busy_vec, RST ? 32'h0 : m_busy);
    endtask

    task automatic tick();
        m_conf = c_wen[0] && c_wen[1] && c_wsel[0] == c_wsel[1];
        for (int j = 0; j < 2; j++) begin
            if (c_wen[j] && c_wsel[j] != 0) m_reg[c_wsel[j]] = c_wdat[j];
        end
        for (int j = 0; j < 2; j++) begin
            if (c_wen[j]) m_busy[c_wsel[j]] = 1'b0;
        end
        if (c_ien && c_isel != 0) m_busy[c_isel] = 1'b1;
        @(posedge CLK);
        #1;
        check("byp_wconflict", bb.wconflict, m_conf);
        check("nob_wconflict", nb.wconflict, m_conf);
        check("byp_busy_after", bb.busy_vec, m_busy);
    endtask

    function automatic logic [63:0] pat(input int r);
        if (r == 0) return '0;
        return {32'(r) * 32'h9E3779B9, ~32'(r)};
    endfunction

    initial begin
        RST = 1'b1;
        model_reset();
        idle(5'd0, 5'd0);
        wb.wen = '0; wb.wsel = '0; wb.wdat = '0; wb.rsel = '0;
        wb.issue_en = 1'b0; wb.issue_sel = '0;
        #3;
        check_comb();
        check("rst_wconflict", bb.wconflict, 1'b0);
        check("rst_wide_busy", wb.busy_vec, 64'h0);
        #9 RST = 1'b0;
        @(posedge CLK);
        #1;

        // write reg 5, read back on both ports, then async reset mid-cycle
        idle(5'd0, 5'd0);
        c_wen = 2'b01; c_wsel[0] = 5'd5; c_wdat[0] = 32'hDEADBEEF;
        drive(); #3; check_comb(); tick();
        idle(5'd5, 5'd5);
        #3;
        check_comb();
        check("rd5_p0", bb.rdat[31:0], 32'hDEADBEEF);
        check("rd5_p1", bb.rdat[63:32], 32'hDEADBEEF);
        #1 RST = 1'b1;
        model_reset();
        #1;
        check_comb();
        check("async_rst_rdat", bb.rdat, 64'h0);
        #2 RST = 1'b0;
        @(posedge CLK);
        #1;

        // same-cycle bypass vs. no bypass
        idle(5'd7, 5'd0);
        c_wen = 2'b10; c_wsel[1] = 5'd7; c_wdat[1] = 32'h12345678;
        drive(); #3;
        check_comb();
        check("bypass_on", bb.rdat[31:0], 32'h12345678);
        check("bypass_off", nb.rdat[31:0], 32'h0);
        tick();
        idle(5'd7, 5'd0);
        #3;
        check_comb();
        check("nob_after_edge", nb.rdat[31:0], 32'h12345678);
        tick();

        // two ports collide on reg 9, highest port wins, one-cycle conflict pulse
        idle(5'd9, 5'd9);
        c_wen = 2'b11; c_wsel[0] = 5'd9; c_wsel[1] = 5'd9;
        c_wdat[0] = 32'hAAAA0000; c_wdat[1] = 32'hBBBB0000;
        drive(); #3; check_comb(); tick();
        check("conflict_pulse", bb.wconflict, 1'b1);
        idle(5'd9, 5'd9);
        #3;
        check_comb();
        check("reg9_winner", nb.rdat[31:0], 32'hBBBB0000);
        tick();
        check("conflict_clear", bb.wconflict, 1'b0);

        // reg 0 is never written and never busy
        idle(5'd0, 5'd0);
        c_wen = 2'b01; c_wsel[0] = 5'd0; c_wdat[0] = 32'hFFFFFFFF;
        c_ien = 1'b1; c_isel = 5'd0;
        drive(); #3;
        check_comb();
        check("reg0_bypass", bb.rdat[31:0], 32'h0);
        tick();
        check("reg0_not_busy", bb.busy_vec[0], 1'b0);

        // scoreboard: issue, write+issue keeps busy, lone write clears
        idle(5'd3, 5'd0);
        c_ien = 1'b1; c_isel = 5'd3;
        drive(); #3; check_comb(); tick();
        idle(5'd3, 5'd0);
        #3;
        check_comb();
        check("rbusy3_set", bb.rbusy[0], 1'b1);
        c_wen = 2'b01; c_wsel[0] = 5'd3; c_wdat[0] = 32'h33;
        c_ien = 1'b1; c_isel = 5'd3;
        drive(); #3; check_comb(); tick();
        check("busy3_kept", bb.busy_vec[3], 1'b1);
        idle(5'd3, 5'd0);
        c_wen = 2'b01; c_wsel[0] = 5'd3; c_wdat[0] = 32'h34;
        drive(); #3;
        check_comb();
        check("rbusy3_byp_clear", bb.rbusy[0], 1'b0);
        check("rbusy3_nob_held", nb.rbusy[0], 1'b1);
        tick();
        check("busy3_cleared", bb.busy_vec[3], 1'b0);

        // randomized traffic on a narrow address window to provoke collisions
        for (int n = 0; n < 300; n++) begin
            c_wen = 2'($urandom_range(0, 3));
            for (int j = 0; j < 2; j++) begin
                c_wsel[j] = 5'($urandom_range(0, 7));
                c_wdat[j] = $urandom;
                c_rsel[j] = 5'($urandom_range(0, 7));
            end
            c_ien  = ($urandom_range(0, 3) == 0);
            c_isel = 5'($urandom_range(0, 7));
            drive(); #3; check_comb(); tick();
        end
        idle(5'd0, 5'd0);

        // wide instance: fill all nonzero registers, read back four at a time
        for (int r = 1; r < 64; r++) begin
            wb.wen = 1'b1; wb.wsel = 6'(r); wb.wdat = pat(r);
            @(posedge CLK);
            #1;
        end
        wb.wen = 1'b0;
        for (int base = 0; base < 64; base += 4) begin
            wb.rsel = {6'(base + 3), 6'(base + 2), 6'(base + 1), 6'(base)};
            #3;
            for (int i = 0; i < 4; i++) begin
                check("wide_rdat", wb.rdat[i*64 +: 64], pat(base + i));
            end
            @(posedge CLK);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
Parametrised multi-port successor to the single-write, two-read register file, for superscalar and multicore datapaths. Provides NREAD combinational read ports and NWRITE write ports. Adds optional write-to-read bypass, deterministic write-port priority with conflict flagging, and a per-register busy scoreboard for hazard detection by the issue stage. Writes on the rising edge.

Parameters:
DATA_W, 32, bits per register
NREGS, 32, register count (power of two, >= 2)
ADDR_W, $clog2(NREGS), register select width
NREAD, 2, read ports (1..4)
NWRITE, 2, write ports (1..4)
BYPASS, 1, 1 = same-cycle write data forwarded to matching reads
ZERO_REG, 1, 1 = register 0 hard-wired to zero, never written, never busy

Ports:
CLK  in  1  clock, rising edge active
RST  in  1  reset, asynchronous, active-high
rsel  in  NREAD*ADDR_W  read selects; port i at [i*ADDR_W +: ADDR_W]
rdat  out  NREAD*DATA_W  read data; port i at [i*DATA_W +: DATA_W]
rbusy  out  NREAD  busy bit of the register selected by each read port
wen  in  NWRITE  write enables
wsel  in  NWRITE*ADDR_W  write selects
wdat  in  NWRITE*DATA_W  write data
issue_en  in  1  mark register issue_sel busy (pending producer)
issue_sel  in  ADDR_W  destination register being issued
busy_vec  out  NREGS  full scoreboard state
wconflict  out  1  registered flag: two or more enabled write ports targeted the same register last cycle

Behaviour:
- Reset (RST=1, async): all registers <= 0; busy_vec <= 0; wconflict <= 0. With storage cleared, rdat reads 0 and rbusy reads 0 while RST is high.
- Write: on a rising CLK edge, for each j with wen[j]=1, reg[wsel[j]] <= wdat[j].
- ZERO_REG=1: writes to reg 0 are dropped.
- Same-address writes: if multiple enabled ports share a wsel, the highest port index wins.
- wconflict: set to 1 on the next edge after any same-address collision, including collisions on reg 0. Cleared on the first edge with no collision, so it is a one-cycle pulse per colliding cycle.
- Read: combinational, zero latency. rdat[i] = reg[rsel[i]].
- BYPASS=1: if any enabled write port targets rsel[i] in the same cycle, rdat[i] = that port's wdat (highest index on collision). Never bypassed for reg 0 when ZERO_REG=1.
- BYPASS=0: reads return the old value until after the edge.
- ZERO_REG=1: rdat for reg 0 is always 0.
- Scoreboard:
  - Busy bit set on the edge where issue_en=1.
  - Busy bit cleared on the edge where any enabled write targets that register.
  - Issue and write to the same register in the same cycle: busy stays 1. The issue belongs to a new producer; the write retires the older one.
  - issue_sel=0 with ZERO_REG=1 is ignored.
- rbusy[i] = busy_vec[rsel[i]], combinational.
- BYPASS=1: rbusy[i] reads 0 if a same-cycle write targets rsel[i] and no same-cycle issue targets it.
- Async reset mid-operation clears all state immediately. The first edge after deassertion behaves as a normal cycle.
- No multicycle paths; all outputs other than wconflict are combinational from state and inputs.

Decomposition:
- Shared package cpu_types_pkg gains:
  - rf_sel_t (logic [ADDR_W-1:0], default width 5)
  - word_t, reused for the DATA_W=32 default
  - localparam RF_MAX_PORTS = 4
- Sub-module rf_scoreboard holds busy_vec and the set/clear/priority logic. Parameters: NREGS, NWRITE, ZERO_REG. Inputs: the write enables/selects and issue signals.
- Storage, write priority, bypass and the conflict detector stay in the top module.

Test Plan:
- Reset, then write 0xDEADBEEF to reg 5 via port 0, read reg 5 on both read ports the next cycle -> rdat = 0xDEADBEEF on both; assert RST async mid-cycle -> rdat = 0 immediately.
- BYPASS=1: in one cycle, wen[1]=1, wsel[1]=7, wdat[1]=0x12345678, rsel[0]=7 -> rdat[0] = 0x12345678 in that cycle. Repeat with BYPASS=0 -> old value 0 until after the edge.
- Ports 0 and 1 both write reg 9 (0xAAAA0000 and 0xBBBB0000) -> reg 9 = 0xBBBB0000; wconflict = 1 for exactly one cycle after the edge.
- Write 0xFFFFFFFF to reg 0 and issue reg 0 -> rdat reads 0 for reg 0; busy_vec[0] stays 0; read of reg 0 still 0 with BYPASS=1.
- Issue reg 3 -> busy_vec[3]=1 next cycle and rbusy=1 when rsel=3. Write reg 3 together with issue reg 3 in one cycle -> busy stays 1. Write reg 3 alone the next cycle -> busy clears, and rbusy reads 0 during the write cycle when BYPASS=1.
- Parameter sweep NREAD=4, NWRITE=1, NREGS=64, DATA_W=64: write a distinct 64-bit pattern to all 63 nonzero registers, read back four at a time -> all match, and the reg 0 read is 0.
